// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - parametrised HD/VD/DEN timing generator with pixel-enable divider
// Optional colour-bar test pattern on R/G/B when LCD_TPG_EN is defined.
module lcd_timing_gen #(
  parameter int H_ACT    = 800,
  parameter int H_BP     = 216,
  parameter int H_TOTAL  = 1056,
  parameter int H_SYNC   = 1,
  parameter int V_ACT    = 480,
  parameter int V_BP     = 35,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 1,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic CLOCK_50,
  input  logic GREST,
  input  logic restart,
  output logic pix_en,
  output logic HD,
  output logic VD,
  output logic DEN,
  output logic [((H_ACT > 1) ? $clog2(H_ACT) : 1)-1:0] columna,
  output logic [((V_ACT > 1) ? $clog2(V_ACT) : 1)-1:0] fila,
  output logic line_start,
  output logic frame_start
`ifdef LCD_TPG_EN
  ,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B
`endif
);

  localparam int CW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int RW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_L = HW'(H_SYNC);
  localparam logic [HW-1:0] H_BP_L   = HW'(H_BP);
  localparam logic [HW-1:0] H_END_L  = HW'(H_BP + H_ACT);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_L = VW'(V_SYNC);
  localparam logic [VW-1:0] V_BP_L   = VW'(V_BP);
  localparam logic [VW-1:0] V_END_L  = VW'(V_BP + V_ACT);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic          POL      = (SYNC_POL != 0);

  generate
    if ((H_BP + H_ACT > H_TOTAL) || (V_BP + V_ACT > V_TOTAL)) begin : g_bad_cfg
      $error("lcd_timing_gen: visible window does not fit inside the total line/frame");
    end
  endgenerate

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] w_v_nxt;
  logic          w_hvis;
  logic          w_vvis;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;

  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DW'(1);

  // A restart strobe makes this pixel (0,0) and lets the counters continue from there.
  assign w_h = restart ? '0 : r_h;
  assign w_v = restart ? '0 : r_v;

  assign w_h_nxt = (w_h == H_LAST) ? '0 : w_h + HW'(1);
  assign w_v_nxt = (w_h != H_LAST) ? w_v :
                   ((w_v == V_LAST) ? '0 : w_v + VW'(1));

  assign w_hvis = (w_h >= H_BP_L) && (w_h < H_END_L);
  assign w_vvis = (w_v >= V_BP_L) && (w_v < V_END_L);
  assign w_col  = CW'(w_h - H_BP_L);
  assign w_row  = RW'(w_v - V_BP_L);

  always_ff @(posedge CLOCK_50 or negedge GREST) begin
    if (!GREST) begin
      r_div       <= '0;
      pix_en      <= 1'b0;
      r_h         <= '0;
      r_v         <= '0;
      HD          <= ~POL;
      VD          <= ~POL;
      DEN         <= 1'b0;
      columna     <= '0;
      fila        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_div       <= w_div_nxt;
      pix_en      <= (w_div_nxt == DIV_LAST);
      line_start  <= pix_en && (w_h == '0);
      frame_start <= pix_en && (w_h == '0) && (w_v == '0);
      if (pix_en) begin
        r_h     <= w_h_nxt;
        r_v     <= w_v_nxt;
        HD      <= (w_h < H_SYNC_L) ? POL : ~POL;
        VD      <= (w_v < V_SYNC_L) ? POL : ~POL;
        DEN     <= w_hvis && w_vvis;
        columna <= w_hvis ? w_col : '0;
        fila    <= w_vvis ? w_row : '0;
      end
    end
  end

`ifdef LCD_TPG_EN
  localparam int BAR_W = (H_ACT >= 8) ? (H_ACT / 8) : 1;

  logic [31:0] w_barq;
  logic [2:0]  w_bar;

  assign w_barq = 32'(w_col) / 32'(BAR_W);
  assign w_bar  = (w_barq > 32'd7) ? 3'd7 : w_barq[2:0];

  // Bar order white..black maps each colour channel onto one inverted bit of the bar index.
  always_ff @(posedge CLOCK_50 or negedge GREST) begin
    if (!GREST) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else if (pix_en) begin
      if (w_hvis && w_vvis) begin
        R <= {8{~w_bar[1]}};
        G <= {8{~w_bar[2]}};
        B <= {8{~w_bar[0]}};
      end else begin
        R <= '0;
        G <= '0;
        B <= '0;
      end
    end
  end
`endif

endmodule
